address_lookup: RTL and testbench

Destination-MAC lookup engine; the read side of the address learning table. Accepts one forwarding query per frame from the ingress parser. Scans the learning table entries, SCAN_WIDTH per cycle, and returns an egress port mask. On a unicast hit it also pulses the matched index back to the learning block so that block can bump its saturating hit counter.

---
 rtl/address_table_pkg.sv | 55 +++++
 rtl/address_match_group.sv | 37 +++
 rtl/address_lookup.sv | 165 ++++++++++++++++
 tb/tb_address_lookup.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/address_table_pkg.sv
// -----------------------------------------------------------------------------
// address_table_pkg
// Shared constants, types and helpers for the address learning table and its
// read-side lookup engine.
//   NUM_PORTS / NUM_ENTRIES : switch port count and learning-table depth
//   MAC_W, BROADCAST_MAC    : MAC width and the all-ones broadcast address
//   mac_t, port_t, idx_t    : MAC, port number and table index types
//   lookup_resp_t           : lookup result (egress mask, hit flag, index)
// -----------------------------------------------------------------------------
package address_table_pkg;

   localparam int NUM_PORTS   = 4;
   localparam int NUM_ENTRIES = NUM_PORTS * 4;
   localparam int MAC_W       = 48;
   localparam int PORT_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int IDX_W       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

   // I/G bit: least significant bit of the first transmitted octet.
   localparam int MCAST_BIT   = 40;

   typedef logic [MAC_W-1:0]     mac_t;
   typedef logic [PORT_W-1:0]    port_t;
   typedef logic [IDX_W-1:0]     idx_t;
   typedef logic [NUM_PORTS-1:0] port_mask_t;

   localparam mac_t BROADCAST_MAC = '1;

   typedef struct packed {
      port_mask_t mask;
      logic       hit;
      idx_t       index;
   } lookup_resp_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SCAN,
      ST_RESP
   } lookup_state_t;

   function automatic port_mask_t onehot_mask(input port_t p);
      return port_mask_t'(1) << p;
   endfunction

   // Every port except the one the frame arrived on.
   function automatic port_mask_t flood_mask(input port_t src);
      return ~onehot_mask(src);
   endfunction

   // Group addresses are never looked up; broadcast is a group address too,
   // the explicit compare just documents that.
   function automatic logic is_group_mac(input mac_t mac);
      return mac[MCAST_BIT] | (mac == BROADCAST_MAC);
   endfunction

endpackage

// File: rtl/address_match_group.sv
// -----------------------------------------------------------------------------
// address_match_group
// Combinational SCAN_WIDTH-way MAC comparator with lowest-index priority.
//   dst_mac   : destination MAC being searched for
//   ent_valid : occupied flag of each entry in the group
//   ent_mac   : learned MAC of each entry in the group
//   match     : at least one valid entry matches
//   local_idx : lowest matching position within the group (0 when no match)
// -----------------------------------------------------------------------------
module address_match_group
   import address_table_pkg::*;
#(
   parameter int SCAN_WIDTH = 4,
   parameter int LOC_W      = (SCAN_WIDTH > 1) ? $clog2(SCAN_WIDTH) : 1
) (
   input  mac_t                             dst_mac,
   input  logic [SCAN_WIDTH-1:0]            ent_valid,
   input  logic [SCAN_WIDTH-1:0][MAC_W-1:0] ent_mac,
   output logic                             match,
   output logic [LOC_W-1:0]                 local_idx
);

   // NOTE: every output gets a default before the loop so no path leaves it
   // unassigned; otherwise synthesis infers a latch.
   always_comb begin
      match     = 1'b0;
      local_idx = '0;
      // Walk from the top down so the lowest matching index is written last.
      for (int i = SCAN_WIDTH - 1; i >= 0; i--) begin
         if (ent_valid[i] && (ent_mac[i] == dst_mac)) begin
            match     = 1'b1;
            local_idx = LOC_W'(i);
         end
      end
   end

endmodule

// File: rtl/address_lookup.sv
// -----------------------------------------------------------------------------
// address_lookup
// Destination-MAC lookup engine on the read side of the learning table.
// Takes one query per frame, scans the live table SCAN_WIDTH entries per cycle
// and returns an egress port mask. Unicast hits strobe the matched index back
// to the learning block for its hit counter.
//   clk, rst_n       : clock, synchronous active-low reset
//   req_*            : query handshake, destination MAC, ingress port
//   tbl_valid/mac/port : live learning-table contents
//   resp_*           : result handshake, egress mask, hit flag, matched index
//   hit_pulse/index  : one-cycle hit strobe to the learning block
// -----------------------------------------------------------------------------
module address_lookup
   import address_table_pkg::*;
#(
   parameter int SCAN_WIDTH = 4
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               req_valid,
   output logic                               req_ready,
   input  logic [MAC_W-1:0]                   req_dst_mac,
   input  logic [PORT_W-1:0]                  req_src_port,
   input  logic [NUM_ENTRIES-1:0]             tbl_valid,
   input  logic [NUM_ENTRIES-1:0][MAC_W-1:0]  tbl_mac,
   input  logic [NUM_ENTRIES-1:0][PORT_W-1:0] tbl_port,
   output logic                               resp_valid,
   input  logic                               resp_ready,
   output logic [NUM_PORTS-1:0]               resp_port_mask,
   output logic                               resp_hit,
   output logic [IDX_W-1:0]                   resp_index,
   output logic                               hit_pulse,
   output logic [IDX_W-1:0]                   hit_index
);

   localparam int G     = NUM_ENTRIES / SCAN_WIDTH;
   localparam int GRP_W = (G > 1) ? $clog2(G) : 1;
   localparam int LOC_W = (SCAN_WIDTH > 1) ? $clog2(SCAN_WIDTH) : 1;

   if ((NUM_ENTRIES % SCAN_WIDTH) != 0) begin : g_bad_scan_width
      $error("address_lookup: NUM_ENTRIES must be a multiple of SCAN_WIDTH");
   end

   lookup_state_t state_q, state_d;
   logic [GRP_W-1:0] grp_q, grp_d;
   mac_t             dst_q;
   port_t            src_q;
   lookup_resp_t     resp_q, resp_d;
   logic             hit_pulse_q, pulse_d;
   logic             req_ready_q;
   logic             load;

   // Current scan group, picked from the live table.
   logic [SCAN_WIDTH-1:0]            grp_valid;
   logic [SCAN_WIDTH-1:0][MAC_W-1:0] grp_mac;
   logic                             grp_match;
   logic [LOC_W-1:0]                 grp_local_idx;
   idx_t                             match_idx;

   always_comb begin
      grp_valid = '0;
      grp_mac   = '0;
      for (int i = 0; i < SCAN_WIDTH; i++) begin
         idx_t ent;
         ent          = idx_t'(int'(grp_q) * SCAN_WIDTH + i);
         grp_valid[i] = tbl_valid[ent];
         grp_mac[i]   = tbl_mac[ent];
      end
   end

   address_match_group #(
      .SCAN_WIDTH (SCAN_WIDTH),
      .LOC_W      (LOC_W)
   ) u_match (
      .dst_mac   (dst_q),
      .ent_valid (grp_valid),
      .ent_mac   (grp_mac),
      .match     (grp_match),
      .local_idx (grp_local_idx)
   );

   assign match_idx = idx_t'(int'(grp_q) * SCAN_WIDTH + int'(grp_local_idx));

   always_comb begin
      state_d = state_q;
      grp_d   = grp_q;
      resp_d  = resp_q;
      pulse_d = 1'b0;
      load    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (req_valid && req_ready_q) begin
               load = 1'b1;
               if (is_group_mac(req_dst_mac)) begin
                  state_d = ST_RESP;
                  resp_d  = '{mask: flood_mask(req_src_port), hit: 1'b0, index: '0};
               end else begin
                  state_d = ST_SCAN;
                  grp_d   = '0;
               end
            end
         end
         ST_SCAN: begin
            if (grp_match) begin
               state_d      = ST_RESP;
               pulse_d      = 1'b1;
               resp_d.hit   = 1'b1;
               resp_d.index = match_idx;
               // Destination sits on the ingress segment: filter the frame.
               resp_d.mask  = (tbl_port[match_idx] == src_q) ? '0
                                                            : onehot_mask(tbl_port[match_idx]);
            end else if (grp_q == GRP_W'(G - 1)) begin
               state_d = ST_RESP;
               resp_d  = '{mask: flood_mask(src_q), hit: 1'b0, index: '0};
            end else begin
               grp_d = grp_q + 1'b1;
            end
         end
         ST_RESP: begin
            if (resp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   // NOTE: datapath registers are reset as well so all outputs read 0 during
   // reset and an abandoned query leaves nothing behind.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         grp_q       <= '0;
         dst_q       <= '0;
         src_q       <= '0;
         resp_q      <= '0;
         hit_pulse_q <= 1'b0;
         req_ready_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         grp_q       <= grp_d;
         resp_q      <= resp_d;
         hit_pulse_q <= pulse_d;
         // Registered so ready stays low throughout reset and rises one
         // cycle after release.
         req_ready_q <= (state_d == ST_IDLE);
         if (load) begin
            dst_q <= req_dst_mac;
            src_q <= req_src_port;
         end
      end
   end

   assign req_ready      = req_ready_q;
   assign resp_valid     = (state_q == ST_RESP);
   assign resp_port_mask = resp_q.mask;
   assign resp_hit       = resp_q.hit;
   assign resp_index     = resp_q.index;
   // Set only on the SCAN->RESP edge, so a stalled RESP never repeats it.
   assign hit_pulse      = hit_pulse_q;
   assign hit_index      = resp_q.index;

endmodule

// File: tb/tb_address_lookup.sv
// -----------------------------------------------------------------------------
// tb_address_lookup
// Directed self-checking bench for address_lookup (4 ports, 16 entries,
// SCAN_WIDTH 4, so four scan groups).
// -----------------------------------------------------------------------------
module tb_address_lookup;
   import address_table_pkg::*;

   logic                               clk;
   logic                               rst_n;
   logic                               req_valid;
   logic                               req_ready;
   logic [MAC_W-1:0]                   req_dst_mac;
   logic [PORT_W-1:0]                  req_src_port;
   logic [NUM_ENTRIES-1:0]             tbl_valid;
   logic [NUM_ENTRIES-1:0][MAC_W-1:0]  tbl_mac;
   logic [NUM_ENTRIES-1:0][PORT_W-1:0] tbl_port;
   logic                               resp_valid;
   logic                               resp_ready;
   logic [NUM_PORTS-1:0]               resp_port_mask;
   logic                               resp_hit;
   logic [IDX_W-1:0]                   resp_index;
   logic                               hit_pulse;
   logic [IDX_W-1:0]                   hit_index;

   int total = 0;
   int bad   = 0;
   int pulse_cnt = 0;

   localparam logic [47:0] MAC_A   = 48'h001122334455;
   localparam logic [47:0] MAC_UNK = 48'h020000000001;
   localparam logic [47:0] MAC_OTH = 48'h00DEADBEEF01;
   localparam logic [47:0] MAC_DUP = 48'h000A0B0C0D0E;
   localparam logic [47:0] MAC_SEG = 48'h001A2B3C4D5E;
   localparam logic [47:0] MAC_FAR = 48'h00AABBCCDDEE;
   localparam logic [47:0] MAC_BC  = 48'hFFFFFFFFFFFF;

   address_lookup #(.SCAN_WIDTH(4)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_dst_mac    (req_dst_mac),
      .req_src_port   (req_src_port),
      .tbl_valid      (tbl_valid),
      .tbl_mac        (tbl_mac),
      .tbl_port       (tbl_port),
      .resp_valid     (resp_valid),
      .resp_ready     (resp_ready),
      .resp_port_mask (resp_port_mask),
      .resp_hit       (resp_hit),
      .resp_index     (resp_index),
      .hit_pulse      (hit_pulse),
      .hit_index      (hit_index)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (hit_pulse === 1'b1) pulse_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue one query, wait for the response, check it, optionally stall the
   // consumer for 'stall' cycles, then complete the handshake.
   task automatic run_case(input string tag, input logic [47:0] mac, input logic [1:0] src,
                           input int exp_lat, input logic [3:0] exp_mask,
                           input logic exp_hit, input logic [3:0] exp_idx, input int stall);
      int n;
      int lat;
      int pc0;
      pc0          = pulse_cnt;
      resp_ready   = (stall == 0);
      req_dst_mac  = mac;
      req_src_port = src;
      req_valid    = 1'b1;
      n = 0;
      while (req_ready !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check({tag, ".req_ready"}, 64'(req_ready), 64'(1'b1));
      tick();                       // handshake edge T
      req_valid   = 1'b0;
      req_dst_mac = ~mac;           // must be ignored after the handshake
      lat = 1;
      while (resp_valid !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
      check({tag, ".mask"}, 64'(resp_port_mask), 64'(exp_mask));
      check({tag, ".hit"}, 64'(resp_hit), 64'(exp_hit));
      check({tag, ".index"}, 64'(resp_index), 64'(exp_idx));
      check({tag, ".hit_pulse"}, 64'(hit_pulse), 64'(exp_hit));
      if (exp_hit) check({tag, ".hit_index"}, 64'(hit_index), 64'(exp_idx));
      for (int i = 0; i < stall; i++) begin
         tick();
         check({tag, ".stall_valid"}, 64'(resp_valid), 64'(1'b1));
         check({tag, ".stall_mask"}, 64'(resp_port_mask), 64'(exp_mask));
         check({tag, ".stall_hit"}, 64'(resp_hit), 64'(exp_hit));
         check({tag, ".stall_index"}, 64'(resp_index), 64'(exp_idx));
         check({tag, ".stall_req_ready"}, 64'(req_ready), 64'(1'b0));
         check({tag, ".stall_pulse"}, 64'(hit_pulse), 64'(1'b0));
      end
      resp_ready = 1'b1;
      tick();
      check({tag, ".after_valid"}, 64'(resp_valid), 64'(1'b0));
      check({tag, ".after_req_ready"}, 64'(req_ready), 64'(1'b1));
      check({tag, ".pulse_count"}, 64'(pulse_cnt - pc0), 64'(exp_hit));
   endtask

   initial begin
      int pc0;
      rst_n        = 1'b0;
      req_valid    = 1'b0;
      req_dst_mac  = '0;
      req_src_port = '0;
      resp_ready   = 1'b1;
      tbl_valid    = '0;
      tbl_mac      = '0;
      tbl_port     = '0;

      // Table: entry 1 holds MAC_A but is unoccupied; entry 9 is the live copy.
      tbl_mac[1]  = MAC_A;   tbl_port[1]  = 2'd3;
      tbl_mac[2]  = MAC_OTH; tbl_port[2]  = 2'd3; tbl_valid[2]  = 1'b1;
      tbl_mac[9]  = MAC_A;   tbl_port[9]  = 2'd2; tbl_valid[9]  = 1'b1;
      tbl_mac[3]  = MAC_DUP; tbl_port[3]  = 2'd1; tbl_valid[3]  = 1'b1;
      tbl_mac[12] = MAC_DUP; tbl_port[12] = 2'd2; tbl_valid[12] = 1'b1;
      tbl_mac[5]  = MAC_SEG; tbl_port[5]  = 2'd1; tbl_valid[5]  = 1'b1;
      tbl_mac[14] = MAC_FAR; tbl_port[14] = 2'd3; tbl_valid[14] = 1'b1;

      // Reset state.
      tick();
      tick();
      check("rst.req_ready", 64'(req_ready), 64'(1'b0));
      check("rst.resp_valid", 64'(resp_valid), 64'(1'b0));
      check("rst.hit_pulse", 64'(hit_pulse), 64'(1'b0));
      check("rst.mask", 64'(resp_port_mask), 64'(4'b0000));
      check("rst.hit", 64'(resp_hit), 64'(1'b0));
      check("rst.index", 64'(resp_index), 64'(4'd0));
      rst_n = 1'b1;
      tick();
      check("rst.release_ready", 64'(req_ready), 64'(1'b1));

      //        tag         mac      src   lat mask     hit   idx    stall
      run_case("hit9",      MAC_A,   2'd0, 4,  4'b0100, 1'b1, 4'd9,  0);
      run_case("miss",      MAC_UNK, 2'd0, 5,  4'b1110, 1'b0, 4'd0,  0);
      run_case("bcast",     MAC_BC,  2'd3, 1,  4'b0111, 1'b0, 4'd0,  0);
      run_case("dup",       MAC_DUP, 2'd0, 2,  4'b0010, 1'b1, 4'd3,  0);
      run_case("same_seg",  MAC_SEG, 2'd1, 3,  4'b0000, 1'b1, 4'd5,  0);
      run_case("stall",     MAC_FAR, 2'd0, 5,  4'b1000, 1'b1, 4'd14, 3);

      // Reset while scanning for a hit in the last group.
      pc0          = pulse_cnt;
      req_dst_mac  = MAC_FAR;
      req_src_port = 2'd0;
      req_valid    = 1'b1;
      tick();                       // handshake, SCAN group 0 follows
      req_valid = 1'b0;
      tick();                       // SCAN group 1
      rst_n = 1'b0;
      tick();
      check("midrst.resp_valid", 64'(resp_valid), 64'(1'b0));
      check("midrst.req_ready", 64'(req_ready), 64'(1'b0));
      check("midrst.hit_pulse", 64'(hit_pulse), 64'(1'b0));
      tick();
      rst_n = 1'b1;
      tick();
      check("midrst.release_ready", 64'(req_ready), 64'(1'b1));
      check("midrst.release_valid", 64'(resp_valid), 64'(1'b0));
      tick();
      tick();
      check("midrst.no_pulse", 64'(pulse_cnt - pc0), 64'(0));

      run_case("post_rst",  MAC_A,   2'd0, 4,  4'b0100, 1'b1, 4'd9,  0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
